// File: rtl/imm_gen_stage.sv
// Decode-stage immediate generator: classifies RV base formats, sign-extends the
// immediate to XLEN and buffers results behind a valid/ready handshake with a skid entry.
module imm_gen_stage #(
  parameter int XLEN       = 32,
  parameter int SHAMT_ZEXT = 0,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instruction,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm,
  output logic [2:0]       fmt,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_count
);

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_ILL = 3'd7;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            illegal;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] inst);
    dec_t               d;
    logic signed [31:0] imm_s;
    logic               shamt;
    imm_s     = '0;
    d.fmt     = FMT_R;
    d.illegal = 1'b0;
    // OP-IMM slli/srli/srai carry a shift amount, not a signed offset
    shamt = (SHAMT_ZEXT != 0) && (inst[6:0] == 7'b0010011) && (inst[13:12] == 2'b01);
    case (inst[6:0])
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: begin
        d.fmt = FMT_I;
        imm_s = {{20{inst[31]}}, inst[31:20]};
      end
      7'b0100011: begin
        d.fmt = FMT_S;
        imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      end
      7'b1100011: begin
        d.fmt = FMT_B;
        imm_s = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        d.fmt = FMT_U;
        imm_s = {inst[31:12], 12'b0};
      end
      7'b1101111: begin
        d.fmt = FMT_J;
        imm_s = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      end
      7'b0110011: begin
        d.fmt = FMT_R;
        imm_s = '0;
      end
      default: begin
        d.fmt     = FMT_ILL;
        d.illegal = 1'b1;
        imm_s     = '0;
      end
    endcase
    if (shamt)
      d.imm = (XLEN == 64) ? XLEN'(inst[25:20]) : XLEN'(inst[24:20]);
    else
      d.imm = XLEN'(imm_s);
    return d;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  dec_t             out_q, out_d;
  dec_t             skid_q, skid_d;
  logic             out_valid_q, out_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  dec_t             in_dec;
  logic             accept;
  logic             out_load;

  always_comb begin
    in_dec       = decode(instruction);
    accept       = in_valid & ~skid_valid_q;
    out_load     = ~out_valid_q | out_ready;
    out_d        = out_q;
    skid_d       = skid_q;
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    cnt_d        = cnt_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else begin
      if (out_load) begin
        // A full skid always drains first; in_ready is low then, so no accept competes
        if (skid_valid_q) begin
          out_d        = skid_q;
          out_valid_d  = 1'b1;
          skid_valid_d = 1'b0;
        end else if (accept) begin
          out_d       = in_dec;
          out_valid_d = 1'b1;
        end else begin
          out_valid_d = 1'b0;
        end
      end else if (accept) begin
        skid_d       = in_dec;
        skid_valid_d = 1'b1;
      end
      if (accept && in_dec.illegal)
        cnt_d = sat_inc(cnt_q);
    end
  end

  // Output / skid register boundary
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      out_q        <= out_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      cnt_q        <= cnt_d;
    end
  end

  assign in_ready      = ~skid_valid_q;
  assign out_valid     = out_valid_q;
  assign imm           = out_q.imm;
  assign fmt           = out_q.fmt;
  assign illegal       = out_q.illegal;
  assign illegal_count = cnt_q;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Scoreboard bench for imm_gen_stage: XLEN=32/CNT_W=2 and XLEN=64/CNT_W=8 instances
// driven in lockstep with directed instruction vectors.
module tb_imm_gen_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] instruction = '0;

  logic        in_ready32, out_valid32, illegal32;
  logic [31:0] imm32;
  logic [2:0]  fmt32;
  logic [1:0]  cnt32;
  logic        in_ready64, out_valid64, illegal64;
  logic [63:0] imm64;
  logic [2:0]  fmt64;
  logic [7:0]  cnt64;

  always #5 clk = ~clk;

  imm_gen_stage #(.XLEN(32), .SHAMT_ZEXT(0), .CNT_W(2)) dut32 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
    .instruction(instruction), .out_valid(out_valid32), .out_ready(out_ready),
    .imm(imm32), .fmt(fmt32), .illegal(illegal32), .illegal_count(cnt32));

  imm_gen_stage #(.XLEN(64), .SHAMT_ZEXT(0), .CNT_W(8)) dut64 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .instruction(instruction), .out_valid(out_valid64), .out_ready(out_ready),
    .imm(imm64), .fmt(fmt64), .illegal(illegal64), .illegal_count(cnt64));

  // Hand-computed vectors: instruction, 64-bit immediate (low half for XLEN=32), format
  localparam int NV = 13;
  logic [31:0] v_inst [NV] = '{
    32'hFFF00093, 32'hFE112E23, 32'h00000463, 32'h123452B7, 32'h800000EF,
    32'h002081B3, 32'hFFFFF517, 32'h00412083, 32'hFE000EE3, 32'h00008067,
    32'h0000007F, 32'h7FF00073, 32'h7FFFF06F};
  logic [63:0] v_imm [NV] = '{
    64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC, 64'h0000000000000008, 64'h0000000012345000,
    64'hFFFFFFFFFFF00000, 64'h0000000000000000, 64'hFFFFFFFFFFFFF000, 64'h0000000000000004,
    64'hFFFFFFFFFFFFFFFC, 64'h0000000000000000, 64'h0000000000000000, 64'h00000000000007FF,
    64'h00000000000FFFFE};
  logic [2:0] v_fmt [NV] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd4, 3'd1, 3'd3, 3'd1,
                             3'd7, 3'd1, 3'd5};

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cur_idx = 0;
  int   ill_model = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic chk_cnt(input string name);
    check({name, "_cnt32"}, 64'(cnt32), (ill_model > 3) ? 64'd3 : 64'(ill_model));
    check({name, "_cnt64"}, 64'(cnt64), (ill_model > 255) ? 64'd255 : 64'(ill_model));
  endtask

  // Monitor: compare whatever is presented against the scoreboard head, pop on fire
  always @(negedge clk) begin
    exp_t e;
    if (out_valid32 || out_valid64) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL spurious_output valid32=%b valid64=%b expected=no output", out_valid32, out_valid64);
      end else begin
        e = sb[0];
        check("out_valid32", 64'(out_valid32), 64'd1);
        check("out_valid64", 64'(out_valid64), 64'd1);
        check("imm32", 64'(imm32), {32'h0, e.imm[31:0]});
        check("imm64", imm64, e.imm);
        check("fmt32", 64'(fmt32), 64'(e.fmt));
        check("fmt64", 64'(fmt64), 64'(e.fmt));
        check("illegal32", 64'(illegal32), 64'(e.ill));
        check("illegal64", 64'(illegal64), 64'(e.ill));
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  // Inputs are set just after a rising edge; acceptance is decided just before the next one
  task automatic step(input bit chk_lat, output bit acc);
    exp_t e;
    #7;
    acc = in_valid && in_ready32 && !flush;
    if (acc) begin
      e.imm = v_imm[cur_idx];
      e.fmt = v_fmt[cur_idx];
      e.ill = (v_fmt[cur_idx] == 3'd7);
      sb.push_back(e);
      if (e.ill) ill_model++;
    end
    @(posedge clk);
    #1;
    if (flush) sb.delete();
    if (acc && chk_lat) begin
      check("latency32", 64'(out_valid32), 64'd1);
      check("latency64", 64'(out_valid64), 64'd1);
    end
  endtask

  task automatic idle(input int n);
    bit acc;
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) step(1'b0, acc);
  endtask

  task automatic send(input int idx, input bit chk_lat);
    bit acc;
    int tries;
    instruction = v_inst[idx];
    cur_idx     = idx;
    in_valid    = 1'b1;
    acc         = 1'b0;
    tries       = 0;
    while (!acc && tries < 20) begin
      step(chk_lat, acc);
      tries++;
    end
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout idx=%0d actual=not accepted required=accepted", idx);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    #2;
    check("rst_out_valid", 64'(out_valid32 | out_valid64), 64'd0);
    check("rst_in_ready", 64'({in_ready32, in_ready64}), 64'd3);
    check("rst_imm", imm64 | 64'(imm32), 64'd0);
    check("rst_fmt_ill", 64'({fmt32, fmt64, illegal32, illegal64}), 64'd0);
    chk_cnt("rst");
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Every legal vector back to back with out_ready=1: one result per cycle
    out_ready = 1'b1;
    for (int i = 0; i < NV; i++) if (i != 10) send(i, 1'b1);
    idle(2);
    check("drain_basic", 64'(sb.size()), 64'd0);

    // Single illegal, then four more to saturate the 2-bit counter
    send(10, 1'b1);
    idle(1);
    chk_cnt("ill1");
    for (int i = 0; i < 4; i++) send(10, 1'b1);
    idle(2);
    chk_cnt("ill5");

    // Back-pressure: A, B fill output and skid; C stalls until out_ready rises
    out_ready = 1'b0;
    send(0, 1'b1);
    send(3, 1'b0);
    instruction = v_inst[4];
    cur_idx     = 4;
    in_valid    = 1'b1;
    check("bp_in_ready32", 64'(in_ready32), 64'd0);
    check("bp_in_ready64", 64'(in_ready64), 64'd0);
    step(1'b0, acc);
    step(1'b0, acc);
    check("bp_c_stalled", 64'(acc), 64'd0);
    out_ready = 1'b1;
    send(4, 1'b0);
    idle(3);
    check("drain_bp", 64'(sb.size()), 64'd0);

    // Flush with both entries full and an illegal input offered the same cycle
    out_ready = 1'b0;
    send(5, 1'b1);
    send(7, 1'b0);
    instruction = v_inst[10];
    cur_idx     = 10;
    in_valid    = 1'b1;
    flush       = 1'b1;
    step(1'b0, acc);
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_out_valid", 64'(out_valid32 | out_valid64), 64'd0);
    check("flush_in_ready", 64'({in_ready32, in_ready64}), 64'd3);
    chk_cnt("flush");
    out_ready = 1'b1;
    send(2, 1'b1);
    idle(2);
    check("drain_flush", 64'(sb.size()), 64'd0);

    // Asynchronous reset in the middle of a stall
    out_ready = 1'b0;
    send(1, 1'b1);
    send(6, 1'b0);
    in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    sb.delete();
    ill_model = 0;
    check("arst_out_valid", 64'(out_valid32 | out_valid64), 64'd0);
    check("arst_in_ready", 64'({in_ready32, in_ready64}), 64'd3);
    check("arst_imm", imm64 | 64'(imm32), 64'd0);
    check("arst_fmt_ill", 64'({fmt32, fmt64, illegal32, illegal64}), 64'd0);
    chk_cnt("arst");
    @(posedge clk);
    #1;
    reset     = 1'b0;
    out_ready = 1'b1;
    send(2, 1'b1);
    idle(2);
    check("drain_arst", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imm_gen_stage.md
Name: imm_gen_stage

Overview:
- Registered, parametrised immediate generator for the decode stage.
- Classifies each instruction into a full RV base format (R/I/S/B/U/J) and sign-extends the immediate to XLEN.
- Flags illegal opcodes and keeps a saturating illegal-instruction counter.
- Sits between fetch and register-read behind a valid/ready handshake, with a one-entry skid buffer so back-pressure never drops an instruction.

Parameters:
- XLEN, 32, immediate output width; legal values 32 or 64; all immediates sign-extended to XLEN.
- SHAMT_ZEXT, 0, when 1, OP-IMM shifts (funct3 001/101) return zero-extended inst[24:20] (XLEN=32) or inst[25:20] (XLEN=64) instead of the sign-extended I immediate.
- CNT_W, 8, width of the saturating illegal-opcode counter.

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- flush  in  1  synchronous; discards all held entries
- in_valid  in  1  instruction present
- in_ready  out  1  stage can accept
- instruction  in  32  raw instruction word
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- imm  out  XLEN  sign-extended immediate
- fmt  out  3  format: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 7=illegal
- illegal  out  1  opcode not recognised
- illegal_count  out  CNT_W  saturating count of accepted illegal instructions

Behaviour:
- Opcode decode on inst[6:0]:
  - 0010011, 0000011, 1100111, 1110011 -> I; imm = sext(inst[31:20])
  - 0100011 -> S; imm = sext({inst[31:25], inst[11:7]})
  - 1100011 -> B; imm = sext({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0})
  - 0110111, 0010111 -> U; imm = sext({inst[31:12], 12'b0})
  - 1101111 -> J; imm = sext({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0})
  - 0110011 -> R; imm = 0
  - Any other opcode -> fmt=7, illegal=1, imm=0.
- Every output is fully assigned on every path; no latch inference.
- Reset (async, immediate on assertion): out_valid=0, skid empty, in_ready=1, imm=0, fmt=0, illegal=0, illegal_count=0. Reset mid-transfer loses held entries; no partial output.
- Latency: an instruction accepted in cycle N (in_valid & in_ready) appears on out_* in cycle N+1 when the output register is empty or draining.
- Output register loads when out_valid=0 or out_ready=1.
- Otherwise the accepted instruction goes to the skid register.
- in_ready = !skid_valid, driven from a register with no combinational path from out_ready.
- Output fire (out_valid & out_ready) with skid full: the skid entry moves to the output register; a simultaneous new input is impossible because in_ready=0.
- Output fire with skid empty and simultaneous accept: the new entry loads the output register directly; out_valid stays 1.
- Ordering is strictly FIFO; zero bubbles under continuous in_valid & out_ready (one result per cycle).
- out_* hold stable while out_valid=1 and out_ready=0.
- flush: next cycle out_valid=0, skid empty, in_ready=1. A same-cycle input is discarded and not counted. flush has priority over all transfers. illegal_count is not cleared by flush.
- illegal_count increments by 1 when an illegal instruction is accepted (not on flush cycles). It saturates at all-ones and never wraps.

Test Plan:
- Basic formats, XLEN=32, out_ready=1: 0xFFF00093 -> imm 0xFFFFFFFF fmt 1; 0xFE112E23 -> 0xFFFFFFFC fmt 2; 0x00000463 -> 0x00000008 fmt 3; 0x123452B7 -> 0x12345000 fmt 4. Each result appears exactly one cycle after acceptance.
- XLEN=64: 0x800000EF (jal, imm[20]=1) -> imm 0xFFFFFFFFFFF00000 fmt 5; 0x123452B7 -> 0x0000000012345000.
- Back-pressure: hold out_ready=0 and send A, B, C back to back. in_ready falls after B; A is held stable; C is stalled. Raise out_ready -> A, B, C emerge in order with no loss or duplication.
- Illegal opcode: send 0x0000007F -> illegal=1, fmt 7, imm 0, illegal_count=1. With CNT_W=2, five illegal instructions -> count saturates at 3.
- Flush with both entries full, input offered in the same cycle: next cycle out_valid=0, in_ready=1, count unchanged; the following instruction passes with one-cycle latency.
- Reset asserted mid-stall (between clock edges): outputs clear immediately to their reset values. After deassertion, 0x00000463 -> imm 0x8 one cycle after acceptance.
